// File: rtl/sync_adder_pkg.sv
// Shared types and helpers for the sync_adder block.
// Provides the default width, a fixed-width sum record and a behavioural
// reference add used by checking code.
package sync_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MAX_WIDTH     = 64;

  // Sum record at the default width: carry above the low DEFAULT_WIDTH bits.
  typedef struct packed {
    logic                     carry;
    logic [DEFAULT_WIDTH-1:0] sum;
  } sum_t;

  // Behavioural {carry, sum} of two width-bit operands, zero-extended to
  // MAX_WIDTH+1 bits; bits above position width are cleared.
  function automatic logic [MAX_WIDTH:0] ref_add(input logic [MAX_WIDTH-1:0] a,
                                                 input logic [MAX_WIDTH-1:0] b,
                                                 input int unsigned          width);
    logic [MAX_WIDTH:0] s;
    logic [MAX_WIDTH:0] mask;
    s    = {1'b0, a} + {1'b0, b};
    mask = ((MAX_WIDTH+1)'(1) << (width + 1)) - (MAX_WIDTH+1)'(1);
    return s & mask;
  endfunction

endpackage

// File: rtl/sync_adder_if.sv
// Operand/result bundle for sync_adder.
// master drives in_valid, a, b and observes result, carry_out, out_valid;
// slave (the adder) is the reverse.
interface sync_adder_if #(
  parameter int unsigned WIDTH = sync_adder_pkg::DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             out_valid;

  modport master (
    output in_valid, a, b,
    input  result, carry_out, out_valid
  );

  modport slave (
    input  in_valid, a, b,
    output result, carry_out, out_valid
  );

endinterface

// File: rtl/full_adder_bit.sv
// One-bit full adder, the cell of the sync_adder ripple chain.
// Ports: x, y operand bits; cin carry in; s sum bit; cout carry out.
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = x ^ y;
  assign s    = p ^ cin;
  // Generate when both bits set, propagate incoming carry when exactly one set.
  assign cout = (x & y) | (cin & p);

endmodule

// File: rtl/sync_adder.sv
// Registered unsigned adder: {carry_out, result} = a + b, one cycle latency.
// Ports: clk; rst (synchronous, active-high); bus (sync_adder_if.slave)
//   carrying in_valid, a, b in and result, carry_out, out_valid out.
// result/carry_out hold their last value while in_valid is low.
module sync_adder
  import sync_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  sync_adder_if.slave  bus
);

  logic [WIDTH:0]   carry_c;
  logic [WIDTH-1:0] sum_c;

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d,  carry_q;
  logic             valid_d,  valid_q;

  // Ripple chain: carry_c[0] is tied low since there is no carry-in.
  assign carry_c[0] = 1'b0;

  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
    full_adder_bit u_fa (
      .x    (bus.a[gi]),
      .y    (bus.b[gi]),
      .cin  (carry_c[gi]),
      .s    (sum_c[gi]),
      .cout (carry_c[gi+1])
    );
  end

  // Capture a new sum only on valid input; otherwise hold.
  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    valid_d  = bus.in_valid;
    if (bus.in_valid) begin
      result_d = sum_c;
      carry_d  = carry_c[WIDTH];
    end
  end

  // Output registers; reset wins over an in-flight valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_sync_adder.sv
// Directed self-checking bench for sync_adder at WIDTH=4.
module tb_sync_adder;
  import sync_adder_pkg::*;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sync_adder_if #(.WIDTH(W)) bus ();

  sync_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       v;
    logic [3:0] a;
    logic [3:0] b;
    logic       ov;
    logic       co;
    logic [3:0] res;
  } vec_t;

  vec_t vecs [8];

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ov, input logic co, input logic [3:0] res);
    total++;
    if (bus.out_valid !== ov || bus.carry_out !== co || bus.result !== res) begin
      bad++;
      $display("FAIL %s: got valid=%b carry=%b result=%0d, want valid=%b carry=%b result=%0d",
               name, bus.out_valid, bus.carry_out, bus.result, ov, co, res);
    end
  endtask

  function automatic sum_t model(input logic [3:0] a, input logic [3:0] b);
    logic [MAX_WIDTH:0] s;
    s = ref_add(64'(a), 64'(b), W);
    return sum_t'(s[W:0]);
  endfunction

  initial begin
    sum_t       e;
    logic [3:0] ra, rb;
    logic [3:0] prev;

    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;

    // Hand-computed directed table; row 7 is an idle cycle that must hold row 6.
    vecs[0] = '{"reset",      1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 4'd0};
    vecs[1] = '{"zero_zero",  1'b0, 1'b1, 4'd0,  4'd0,  1'b1, 1'b0, 4'd0};
    vecs[2] = '{"7_plus_7",   1'b0, 1'b1, 4'd7,  4'd7,  1'b1, 1'b0, 4'd14};
    vecs[3] = '{"15_plus_15", 1'b0, 1'b1, 4'd15, 4'd15, 1'b1, 1'b1, 4'd14};
    vecs[4] = '{"8_plus_8",   1'b0, 1'b1, 4'd8,  4'd8,  1'b1, 1'b1, 4'd0};
    vecs[5] = '{"15_plus_1",  1'b0, 1'b1, 4'd15, 4'd1,  1'b1, 1'b1, 4'd0};
    vecs[6] = '{"5_plus_3",   1'b0, 1'b1, 4'd5,  4'd3,  1'b1, 1'b0, 4'd8};
    vecs[7] = '{"idle_hold",  1'b0, 1'b0, 4'd9,  4'd9,  1'b0, 1'b0, 4'd8};

    step(1'b1, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].ov, vecs[i].co, vecs[i].res);
    end

    // Second idle cycle keeps holding the last sum.
    step(1'b0, 1'b0, 4'd3, 4'd4);
    check("idle_hold2", 1'b0, 1'b0, 4'd8);

    // Back-to-back sums with both MSBs clear: never a carry, no bubbles.
    for (int i = 0; i < 10; i++) begin
      ra = 4'($urandom_range(0, 7));
      rb = 4'($urandom_range(0, 7));
      step(1'b0, 1'b1, ra, rb);
      check("no_carry_stream", 1'b1, 1'b0, ra + rb);
    end

    // Exhaustive sweep: full sum, parity of bit 0, and zero-operand identities.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        ra = 4'(ia);
        rb = 4'(ib);
        step(1'b0, 1'b1, ra, rb);
        e = model(ra, rb);
        check("sweep_sum", 1'b1, e.carry, e.sum);
        total++;
        if (bus.result[0] !== (ra[0] ^ rb[0])) begin
          bad++;
          $display("FAIL parity a=%0d b=%0d: got bit0=%b, want %b", ra, rb, bus.result[0], ra[0] ^ rb[0]);
        end
        if (ia == 0) check("ident_a0", 1'b1, 1'b0, rb);
        if (ib == 0) check("ident_b0", 1'b1, 1'b0, ra);
      end
    end

    // Reset in the same cycle as a valid sum discards that sum.
    step(1'b0, 1'b1, 4'd6, 4'd6);
    check("pre_reset", 1'b1, 1'b0, 4'd12);
    step(1'b1, 1'b1, 4'd15, 4'd1);
    check("reset_wins", 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd15, 4'd1);
    check("post_reset_idle", 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd2, 4'd3);
    check("first_after_reset", 1'b1, 1'b0, 4'd5);

    // out_valid is a single-cycle pulse and values persist across idles.
    step(1'b0, 1'b1, 4'd9, 4'd9);
    check("pulse_a", 1'b1, 1'b1, 4'd2);
    prev = 4'd2;
    step(1'b0, 1'b0, 4'd1, 4'd1);
    check("pulse_drop", 1'b0, 1'b1, prev);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
